// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: opcodes, funct codes, ALU control encodings
// and the decoder control bundle.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [31:0] NOP     = 32'h0000_0000;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SUB = 4'b0110,
        ALU_SLT = 4'b0111,
        ALU_ILL = 4'b1111
    } alu_ctrl_e;

    typedef struct packed {
        logic       reg_write;
        logic       mem_to_reg;
        logic       branch;
        logic       mem_read;
        logic       mem_write;
        logic       reg_dst;
        logic [1:0] alu_op;
        logic       alu_src;
    } ctrl_t;

endpackage

// File: rtl/alu_ctrl_dec.sv
// ALU control decoder: maps the decoder ALU class and R-type funct field to the
// 4-bit ALU operation; unknown R-type functs decode as ALU_ILL.
module alu_ctrl_dec
    import mips_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
    output logic [3:0] alu_ctrl
);

    always_comb begin
        alu_ctrl = ALU_ADD;
        unique case (alu_op)
            2'b00: alu_ctrl = ALU_ADD;
            2'b01: alu_ctrl = ALU_SUB;
            2'b11: alu_ctrl = ALU_ADD;
            2'b10: begin
                unique case (funct)
                    FN_ADD:  alu_ctrl = ALU_ADD;
                    FN_SUB:  alu_ctrl = ALU_SUB;
                    FN_AND:  alu_ctrl = ALU_AND;
                    FN_OR:   alu_ctrl = ALU_OR;
                    FN_SLT:  alu_ctrl = ALU_SLT;
                    default: alu_ctrl = ALU_ILL;
                endcase
            end
            default: alu_ctrl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with ALU control generation, load-use hazard
// detection and bubble insertion on stall, flush or illegal ALU operation.
module id_ex_stage
    import mips_pkg::*;
#(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [31:0]   Instruction_ID,
    input  logic          RegWrite_ID,
    input  logic          MemtoReg_ID,
    input  logic          Branch_ID,
    input  logic          MemRead_ID,
    input  logic          MemWrite_ID,
    input  logic          RegDst_ID,
    input  logic [1:0]    ALUOp_ID,
    input  logic          ALUSrc_ID,
    input  logic [DW-1:0] ReadData1_ID,
    input  logic [DW-1:0] ReadData2_ID,
    input  logic [DW-1:0] SignExt_ID,
    input  logic [DW-1:0] PCPlus4_ID,
    input  logic          Flush_ID,
    output logic          RegWrite_EX,
    output logic          MemtoReg_EX,
    output logic          Branch_EX,
    output logic          MemRead_EX,
    output logic          MemWrite_EX,
    output logic          ALUSrc_EX,
    output logic [3:0]    ALUCtrl_EX,
    output logic [DW-1:0] ReadData1_EX,
    output logic [DW-1:0] ReadData2_EX,
    output logic [DW-1:0] SignExt_EX,
    output logic [DW-1:0] PCPlus4_EX,
    output logic [RW-1:0] Rs_EX,
    output logic [RW-1:0] Rt_EX,
    output logic [RW-1:0] WriteReg_EX,
    output logic          Stall_ID,
    output logic          PCWrite,
    output logic          IFIDWrite
);

    ctrl_t         ctrl_id;
    ctrl_t         ctrl_d;
    logic [3:0]    alu_ctrl_id;
    logic [3:0]    alu_ctrl_d;
    logic [RW-1:0] rs_id, rt_id, rd_id;
    logic [RW-1:0] write_reg_d;
    logic          bubble;

    assign ctrl_id = '{reg_write:  RegWrite_ID,
                       mem_to_reg: MemtoReg_ID,
                       branch:     Branch_ID,
                       mem_read:   MemRead_ID,
                       mem_write:  MemWrite_ID,
                       reg_dst:    RegDst_ID,
                       alu_op:     ALUOp_ID,
                       alu_src:    ALUSrc_ID};

    assign rs_id = RW'(Instruction_ID[25:21]);
    assign rt_id = RW'(Instruction_ID[20:16]);
    assign rd_id = RW'(Instruction_ID[15:11]);

    alu_ctrl_dec u_alu_ctrl_dec (
        .alu_op   (ctrl_id.alu_op),
        .funct    (Instruction_ID[5:0]),
        .alu_ctrl (alu_ctrl_id)
    );

    // A taken branch kills the dependent instruction, so the stall is moot.
    assign Stall_ID  = MemRead_EX & (Rt_EX != '0) &
                       ((Rt_EX == rs_id) | (Rt_EX == rt_id)) & ~Flush_ID;
    assign PCWrite   = ~Stall_ID;
    assign IFIDWrite = ~Stall_ID;
    assign bubble    = Stall_ID | Flush_ID | (alu_ctrl_id == ALU_ILL);

    // RegDst/MemtoReg may be X when RegWrite is low; gate them so X never loads.
    always_comb begin
        ctrl_d      = '0;
        alu_ctrl_d  = ALU_ADD;
        write_reg_d = '0;
        if (!bubble) begin
            ctrl_d     = ctrl_id;
            alu_ctrl_d = alu_ctrl_id;
            if (!ctrl_id.reg_write) begin
                ctrl_d.mem_to_reg = 1'b0;
            end else begin
                write_reg_d = ctrl_id.reg_dst ? rd_id : rt_id;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            RegWrite_EX  <= 1'b0;
            MemtoReg_EX  <= 1'b0;
            Branch_EX    <= 1'b0;
            MemRead_EX   <= 1'b0;
            MemWrite_EX  <= 1'b0;
            ALUSrc_EX    <= 1'b0;
            ALUCtrl_EX   <= ALU_ADD;
            ReadData1_EX <= '0;
            ReadData2_EX <= '0;
            SignExt_EX   <= '0;
            PCPlus4_EX   <= '0;
            Rs_EX        <= '0;
            Rt_EX        <= '0;
            WriteReg_EX  <= '0;
        end else begin
            RegWrite_EX  <= ctrl_d.reg_write;
            MemtoReg_EX  <= ctrl_d.mem_to_reg;
            Branch_EX    <= ctrl_d.branch;
            MemRead_EX   <= ctrl_d.mem_read;
            MemWrite_EX  <= ctrl_d.mem_write;
            ALUSrc_EX    <= ctrl_d.alu_src;
            ALUCtrl_EX   <= alu_ctrl_d;
            ReadData1_EX <= ReadData1_ID;
            ReadData2_EX <= ReadData2_ID;
            SignExt_EX   <= SignExt_ID;
            PCPlus4_EX   <= PCPlus4_ID;
            Rs_EX        <= rs_id;
            Rt_EX        <= rt_id;
            WriteReg_EX  <= write_reg_d;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Testbench for id_ex_stage: directed scenarios with literal expectations, then
// randomized instruction streams checked every cycle against a reference model.
module tb_id_ex_stage;
    import mips_pkg::*;

    localparam int DW = 32;
    localparam int RW = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [31:0]   Instruction_ID = '0;
    logic          RegWrite_ID = 1'b0, MemtoReg_ID = 1'b0, Branch_ID = 1'b0;
    logic          MemRead_ID = 1'b0, MemWrite_ID = 1'b0, RegDst_ID = 1'b0;
    logic [1:0]    ALUOp_ID = 2'b00;
    logic          ALUSrc_ID = 1'b0;
    logic [DW-1:0] ReadData1_ID = '0, ReadData2_ID = '0, SignExt_ID = '0, PCPlus4_ID = '0;
    logic          Flush_ID = 1'b0;

    logic          RegWrite_EX, MemtoReg_EX, Branch_EX, MemRead_EX, MemWrite_EX, ALUSrc_EX;
    logic [3:0]    ALUCtrl_EX;
    logic [DW-1:0] ReadData1_EX, ReadData2_EX, SignExt_EX, PCPlus4_EX;
    logic [RW-1:0] Rs_EX, Rt_EX, WriteReg_EX;
    logic          Stall_ID, PCWrite, IFIDWrite;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.DW(DW), .RW(RW)) dut (
        .clk(clk), .rst_n(rst_n), .Instruction_ID(Instruction_ID),
        .RegWrite_ID(RegWrite_ID), .MemtoReg_ID(MemtoReg_ID), .Branch_ID(Branch_ID),
        .MemRead_ID(MemRead_ID), .MemWrite_ID(MemWrite_ID), .RegDst_ID(RegDst_ID),
        .ALUOp_ID(ALUOp_ID), .ALUSrc_ID(ALUSrc_ID),
        .ReadData1_ID(ReadData1_ID), .ReadData2_ID(ReadData2_ID),
        .SignExt_ID(SignExt_ID), .PCPlus4_ID(PCPlus4_ID), .Flush_ID(Flush_ID),
        .RegWrite_EX(RegWrite_EX), .MemtoReg_EX(MemtoReg_EX), .Branch_EX(Branch_EX),
        .MemRead_EX(MemRead_EX), .MemWrite_EX(MemWrite_EX), .ALUSrc_EX(ALUSrc_EX),
        .ALUCtrl_EX(ALUCtrl_EX), .ReadData1_EX(ReadData1_EX), .ReadData2_EX(ReadData2_EX),
        .SignExt_EX(SignExt_EX), .PCPlus4_EX(PCPlus4_EX), .Rs_EX(Rs_EX), .Rt_EX(Rt_EX),
        .WriteReg_EX(WriteReg_EX), .Stall_ID(Stall_ID), .PCWrite(PCWrite), .IFIDWrite(IFIDWrite)
    );

    // Reference model: what EX must hold, derived from the rules directly.
    logic          m_regwrite, m_memtoreg, m_branch, m_memread, m_memwrite, m_alusrc;
    logic [3:0]    m_alu;
    logic [DW-1:0] m_rd1, m_rd2, m_sext, m_pc4;
    logic [4:0]    m_rs, m_rt, m_wr;

    function automatic logic [3:0] ref_alu(input logic [1:0] op, input logic [5:0] f);
        if (op == 2'b01) return 4'b0110;
        if (op != 2'b10) return 4'b0010;
        case (f)
            6'd32:   return 4'b0010;
            6'd34:   return 4'b0110;
            6'd36:   return 4'b0000;
            6'd37:   return 4'b0001;
            6'd42:   return 4'b0111;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic ref_stall(input logic ex_load, input logic [4:0] ex_rt,
                                       input logic [31:0] ins, input logic fl);
        return ex_load && ex_rt != 5'd0 &&
               (ex_rt == ins[25:21] || ex_rt == ins[20:16]) && !fl;
    endfunction

    function automatic logic ref_bubble();
        return ref_stall(m_memread, m_rt, Instruction_ID, Flush_ID) || Flush_ID ||
               ref_alu(ALUOp_ID, Instruction_ID[5:0]) == 4'b1111;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_regwrite <= 0; m_memtoreg <= 0; m_branch <= 0; m_memread <= 0;
            m_memwrite <= 0; m_alusrc <= 0; m_alu <= 4'b0010;
            m_rd1 <= 0; m_rd2 <= 0; m_sext <= 0; m_pc4 <= 0;
            m_rs <= 0; m_rt <= 0; m_wr <= 0;
        end else begin
            m_regwrite <= !ref_bubble() && RegWrite_ID;
            m_memtoreg <= !ref_bubble() && RegWrite_ID && MemtoReg_ID;
            m_branch   <= !ref_bubble() && Branch_ID;
            m_memread  <= !ref_bubble() && MemRead_ID;
            m_memwrite <= !ref_bubble() && MemWrite_ID;
            m_alusrc   <= !ref_bubble() && ALUSrc_ID;
            m_alu      <= ref_bubble() ? 4'b0010 : ref_alu(ALUOp_ID, Instruction_ID[5:0]);
            m_wr       <= (ref_bubble() || !RegWrite_ID) ? 5'd0 :
                          (RegDst_ID ? Instruction_ID[15:11] : Instruction_ID[20:16]);
            m_rd1 <= ReadData1_ID; m_rd2 <= ReadData2_ID;
            m_sext <= SignExt_ID;  m_pc4 <= PCPlus4_ID;
            m_rs <= Instruction_ID[25:21]; m_rt <= Instruction_ID[20:16];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    logic exp_stall;
    always @(negedge clk) begin
        if (rst_n) begin
            exp_stall = ref_stall(m_memread, m_rt, Instruction_ID, Flush_ID);
            check("m_RegWrite_EX", 32'(RegWrite_EX), 32'(m_regwrite));
            check("m_MemtoReg_EX", 32'(MemtoReg_EX), 32'(m_memtoreg));
            check("m_Branch_EX",   32'(Branch_EX),   32'(m_branch));
            check("m_MemRead_EX",  32'(MemRead_EX),  32'(m_memread));
            check("m_MemWrite_EX", 32'(MemWrite_EX), 32'(m_memwrite));
            check("m_ALUSrc_EX",   32'(ALUSrc_EX),   32'(m_alusrc));
            check("m_ALUCtrl_EX",  32'(ALUCtrl_EX),  32'(m_alu));
            check("m_ReadData1_EX", ReadData1_EX, m_rd1);
            check("m_ReadData2_EX", ReadData2_EX, m_rd2);
            check("m_SignExt_EX",  SignExt_EX, m_sext);
            check("m_PCPlus4_EX",  PCPlus4_EX, m_pc4);
            check("m_Rs_EX",       32'(Rs_EX), 32'(m_rs));
            check("m_Rt_EX",       32'(Rt_EX), 32'(m_rt));
            check("m_WriteReg_EX", 32'(WriteReg_EX), 32'(m_wr));
            check("m_Stall_ID",    32'(Stall_ID),  32'(exp_stall));
            check("m_PCWrite",     32'(PCWrite),   32'(!exp_stall));
            check("m_IFIDWrite",   32'(IFIDWrite), 32'(!exp_stall));
        end
    end

    task automatic set_ctrl(input logic rw, input logic mtr, input logic br, input logic mr,
                            input logic mw, input logic rd, input logic [1:0] op, input logic src,
                            input logic fl);
        RegWrite_ID = rw; MemtoReg_ID = mtr; Branch_ID = br; MemRead_ID = mr;
        MemWrite_ID = mw; RegDst_ID = rd; ALUOp_ID = op; ALUSrc_ID = src; Flush_ID = fl;
        ReadData1_ID = $urandom; ReadData2_ID = $urandom;
        SignExt_ID = $urandom;   PCPlus4_ID = $urandom;
    endtask

    task automatic drive_r(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                           input logic [5:0] fn, input logic fl);
        Instruction_ID = {OP_RTYPE, rs, rt, rd, 5'd0, fn};
        set_ctrl(1, 0, 0, 0, 0, 1, 2'b10, 0, fl);
    endtask

    task automatic drive_lw(input logic [4:0] rs, input logic [4:0] rt);
        Instruction_ID = {OP_LW, rs, rt, 16'h0000};
        set_ctrl(1, 1, 0, 1, 0, 0, 2'b00, 1, 0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic random_inst();
        logic [5:0] fns [6];
        int unsigned k;
        logic [4:0] rs, rt, rd;
        logic fl;
        fns = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd42, 6'd0};
        rs = 5'($urandom_range(0, 3)); rt = 5'($urandom_range(0, 3)); rd = 5'($urandom_range(0, 31));
        fl = ($urandom_range(0, 9) == 0);
        k = $urandom_range(0, 9);
        if (k <= 4) begin
            drive_r(rs, rt, rd, (k == 4) ? 6'($urandom) : fns[$urandom_range(0, 5)], fl);
        end else if (k <= 6) begin
            drive_lw(rs, rt);
            Flush_ID = fl;
        end else if (k == 7) begin
            Instruction_ID = {OP_SW, rs, rt, 16'($urandom)};
            set_ctrl(0, 1'($urandom), 0, 0, 1, 1'($urandom), 2'b00, 1, fl);
        end else if (k == 8) begin
            Instruction_ID = {OP_BEQ, rs, rt, 16'($urandom)};
            set_ctrl(0, 0, 1, 0, 0, 0, 2'b01, 0, fl);
        end else begin
            Instruction_ID = {6'($urandom), rs, rt, rd, 11'($urandom)};
            set_ctrl(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                     1'($urandom), 2'($urandom), 1'($urandom), fl);
        end
    endtask

    logic hold;
    initial begin
        set_ctrl(0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
        Instruction_ID = NOP;
        repeat (2) @(negedge clk);
        check("reset_RegWrite_EX", 32'(RegWrite_EX), 32'd0);
        check("reset_ALUCtrl_EX",  32'(ALUCtrl_EX),  32'd2);
        check("reset_WriteReg_EX", 32'(WriteReg_EX), 32'd0);
        check("reset_ReadData1_EX", ReadData1_EX, 32'd0);
        check("reset_PCWrite",     32'(PCWrite),     32'd1);
        check("reset_IFIDWrite",   32'(IFIDWrite),   32'd1);

        #1 rst_n = 1'b1;
        drive_r(5'd1, 5'd2, 5'd3, FN_ADD, 0);
        step();
        check("add_RegWrite_EX", 32'(RegWrite_EX), 32'd1);
        check("add_ALUCtrl_EX",  32'(ALUCtrl_EX),  32'd2);
        check("add_WriteReg_EX", 32'(WriteReg_EX), 32'd3);

        drive_lw(5'd1, 5'd2);
        step();
        drive_r(5'd2, 5'd5, 5'd4, FN_ADD, 0);
        @(negedge clk);
        check("lu_Stall_ID", 32'(Stall_ID), 32'd1);
        check("lu_PCWrite",  32'(PCWrite),  32'd0);
        step();
        check("lu_bubble_RegWrite_EX", 32'(RegWrite_EX), 32'd0);
        check("lu_stall_drops",        32'(Stall_ID),    32'd0);
        step();
        check("lu_add_RegWrite_EX", 32'(RegWrite_EX), 32'd1);
        check("lu_add_WriteReg_EX", 32'(WriteReg_EX), 32'd4);

        drive_lw(5'd1, 5'd0);
        step();
        drive_r(5'd0, 5'd0, 5'd6, FN_ADD, 0);
        @(negedge clk);
        check("r0_no_stall", 32'(Stall_ID), 32'd0);
        step();

        Instruction_ID = {OP_SW, 5'd1, 5'd2, 16'h0004};
        set_ctrl(0, 1'bx, 0, 0, 1, 1'bx, 2'b00, 1, 0);
        step();
        check("sw_MemWrite_EX", 32'(MemWrite_EX), 32'd1);
        check("sw_WriteReg_EX", 32'(WriteReg_EX), 32'd0);
        check("sw_MemtoReg_EX", 32'(MemtoReg_EX), 32'd0);
        check("sw_no_x", 32'($isunknown({RegWrite_EX, MemtoReg_EX, Branch_EX, MemRead_EX,
              MemWrite_EX, ALUSrc_EX, ALUCtrl_EX, WriteReg_EX, Rs_EX, Rt_EX, Stall_ID})), 32'd0);

        drive_lw(5'd1, 5'd3);
        step();
        drive_r(5'd3, 5'd3, 5'd7, FN_SUB, 1);
        @(negedge clk);
        check("flush_Stall_ID", 32'(Stall_ID), 32'd0);
        check("flush_PCWrite",  32'(PCWrite),  32'd1);
        step();
        check("flush_RegWrite_EX", 32'(RegWrite_EX), 32'd0);
        check("flush_ALUCtrl_EX",  32'(ALUCtrl_EX),  32'd2);

        Instruction_ID = NOP;
        set_ctrl(1, 0, 0, 0, 0, 1, 2'b10, 0, 0);
        step();
        check("ill_RegWrite_EX", 32'(RegWrite_EX), 32'd0);
        check("ill_ALUCtrl_EX",  32'(ALUCtrl_EX),  32'd2);

        drive_lw(5'd1, 5'd2);
        step();
        drive_r(5'd2, 5'd2, 5'd8, FN_AND, 0);
        @(negedge clk);
        check("rst_pre_Stall_ID", 32'(Stall_ID), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_Stall_ID",   32'(Stall_ID),   32'd0);
        check("rst_PCWrite",    32'(PCWrite),    32'd1);
        check("rst_MemRead_EX", 32'(MemRead_EX), 32'd0);
        check("rst_ALUCtrl_EX", 32'(ALUCtrl_EX), 32'd2);
        check("rst_Rt_EX",      32'(Rt_EX),      32'd0);
        check("rst_ReadData1",  ReadData1_EX,    32'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        step();

        random_inst();
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            hold = ref_stall(m_memread, m_rt, Instruction_ID, Flush_ID);
            step();
            if (hold) begin
                Flush_ID = ($urandom_range(0, 9) == 0);
                ReadData1_ID = $urandom; ReadData2_ID = $urandom;
            end else begin
                random_inst();
            end
        end
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage that consumes the decode-stage control bundle (`RegWrite_ID`, `MemtoReg_ID`, `Branch_ID`, `MemRead_ID`, `MemWrite_ID`, `RegDst_ID`, `ALUOp_ID[1:0]`, `ALUSrc_ID`) and holds it, with the operands, for the EX stage. It performs the following functions:
- generates the 4-bit ALU control from `ALUOp` and `funct`;
- detects load-use hazards and stalls the front end;
- inserts bubbles on stall or branch flush.

It sits between the main decoder/register file and the ALU/forwarding logic.

## Interface
Parameters:
- `DW`, 32, datapath width
- `RW`, 5, register-index width

Ports. Clock and reset: one clock, `clk`; reset `rst_n` is asynchronous and active-low.
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `Instruction_ID`  in  32  ID-stage instruction (`rs`[25:21], `rt`[20:16], `rd`[15:11], `funct`[5:0])
- `RegWrite_ID`, `MemtoReg_ID`, `Branch_ID`, `MemRead_ID`, `MemWrite_ID`, `RegDst_ID`, `ALUSrc_ID`  in  1 each  decoder control bits; `RegDst_ID`/`MemtoReg_ID` may be X
- `ALUOp_ID`  in  2  decoder ALU class
- `ReadData1_ID`, `ReadData2_ID`, `SignExt_ID`, `PCPlus4_ID`  in  DW each  operands
- `Flush_ID`  in  1  branch taken; kill the ID instruction
- `RegWrite_EX`, `MemtoReg_EX`, `Branch_EX`, `MemRead_EX`, `MemWrite_EX`, `ALUSrc_EX`  out  1 each  registered controls
- `ALUCtrl_EX`  out  4  registered ALU operation
- `ReadData1_EX`, `ReadData2_EX`, `SignExt_EX`, `PCPlus4_EX`  out  DW each  registered operands
- `Rs_EX`, `Rt_EX`  out  RW each  source indices, for forwarding
- `WriteReg_EX`  out  RW  destination index (RegDst mux applied)
- `Stall_ID`  out  1  combinational load-use stall
- `PCWrite`, `IFIDWrite`  out  1 each  equal to `~Stall_ID`

## Operation
- **ALU control** (combinational, ID side):
  - `ALUOp` 00 → 0010 (add).
  - `ALUOp` 01 → 0110 (sub).
  - `ALUOp` 11 → 0010.
  - `ALUOp` 10 decodes `funct`: 100000→0010, 100010→0110, 100100→0000, 100101→0001, 101010→0111.
  - Any other `funct`, including 000000, → 1111 (illegal). The instruction is then loaded as a bubble.
- **Hazard detection**: `Stall_ID = MemRead_EX & (Rt_EX != 0) & ((Rt_EX == rs_ID) | (Rt_EX == rt_ID)) & ~Flush_ID`.
- **Bubble condition**: `Stall_ID | Flush_ID | (ALUCtrl == 1111)`.
  - On a bubble, all 1-bit `_EX` controls load 0, `ALUCtrl_EX` loads 0010 and `WriteReg_EX` loads 0.
  - Data and index registers still load from their ID inputs.
- **Sanitisation**: X inputs must never reach the `_EX` outputs.
  - If `RegWrite_ID` = 0: `WriteReg_EX` ← 0 and `MemtoReg_EX` ← 0, regardless of `RegDst_ID` or `MemtoReg_ID`.
  - Otherwise `WriteReg_EX` ← `RegDst_ID ? rd : rt`.
- **Priority**: Flush > Stall > normal. A flush cancels the stall, so the PC and IF/ID registers advance.
- **Reset**: all `_EX` outputs are 0, `ALUCtrl_EX` = 0010, and the data outputs are 0. `Stall_ID` = 0, so `PCWrite` = `IFIDWrite` = 1.

## Timing
- Latency is one cycle from ID inputs to `_EX` outputs, with no enable: the register loads every edge, either a real instruction or a bubble.
- `Stall_ID`, `PCWrite` and `IFIDWrite` are same-cycle combinational outputs of the `_EX` registers and `Instruction_ID`.
- A load-use sequence stalls exactly one cycle. After the bubble, `MemRead_EX` = 0, so `Stall_ID` drops; the held instruction re-presents and enters EX.
- Back-to-back loads, each dependent on the previous one, produce one stall per pair.
- Reset asserted mid-stall: outputs clear immediately (asynchronous), and `Stall_ID` deasserts in the same instant.
- Deassertion of `rst_n` is synchronised outside this block.

## Structure
- Shared package `mips_pkg`:
  - opcode constants (RTYPE, LW, SW, BEQ, NOP);
  - funct constants;
  - `ALUCtrl` encodings (`ALU_AND`, `ALU_OR`, `ALU_ADD`, `ALU_SUB`, `ALU_SLT`, `ALU_ILL`);
  - packed `ctrl_t` struct of the eight control fields.
- One natural sub-module: `alu_ctrl_dec` (combinational `ALUOp` + `funct` → 4-bit control). It is reused by later stages.
- Top level: hazard equation, bubble mux, and the pipeline register.

## Test plan
- Reset held, then released with an R-type `add` (funct 100000, rs=1, rt=2, rd=3) → one cycle later `RegWrite_EX`=1, `ALUCtrl_EX`=0010, `WriteReg_EX`=3.
- `lw $2,0($1)` followed by `add $4,$2,$5` → `Stall_ID`=1 for exactly one cycle; `PCWrite`=0; bubble in EX (`RegWrite_EX`=0); `add` enters EX on the next edge.
- Load with `rt`=0 followed by a dependent use of `$0` → `Stall_ID` stays 0.
- `sw` with `RegDst_ID`/`MemtoReg_ID` = X → `MemWrite_EX`=1, `WriteReg_EX`=0, `MemtoReg_EX`=0, no X on any output.
- Load-use stall and `Flush_ID` in the same cycle → `Stall_ID`=0, `PCWrite`=1, EX receives a bubble.
- Instruction 0x00000000 → `ALUCtrl` illegal, bubble loaded (`RegWrite_EX`=0, `ALUCtrl_EX`=0010); `rst_n` dropped mid-stall → all outputs at reset values without waiting for a clock edge.
